// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one Duplex UART transmitter among NUM_REQ requesters.
// Optional watchdog abort is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]      req_parity,
    input  logic [NUM_REQ*2-1:0]      req_baud,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      uart_send,
    output logic [DATA_W-1:0]         uart_data,
    output logic [1:0]                uart_parity_type,
    output logic [1:0]                uart_baud_rate,
    input  logic                      uart_tx_active,
    input  logic                      uart_tx_done
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SCAN_W = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACTIVE,
        WAIT_DONE,
        RELEASE
    } state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    ptr, winner, pick;
    logic [SCAN_W-1:0]   scan;
    logic                found;
    logic [DATA_W-1:0]   sel_data;
    logic [1:0]          sel_parity, sel_baud;
    logic                tx_done_q, done_pend, done_rise;

    assign done_rise = uart_tx_done & ~tx_done_q;

    // Scan ptr, ptr+1, ... with modulo wrap; first set request wins.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        scan  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + SCAN_W'(k);
            if (scan >= SCAN_W'(NUM_REQ))
                scan = scan - SCAN_W'(NUM_REQ);
            if (!found && req[scan[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_data   = '0;
        sel_parity = '0;
        sel_baud   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                sel_data   = req_data[k*DATA_W +: DATA_W];
                sel_parity = req_parity[k*2 +: 2];
                sel_baud   = req_baud[k*2 +: 2];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             timed_out, timeout_hit;

    // cnt lags cycles-since-LAUNCH by one, so RELEASE lands TIMEOUT_CYC cycles after LAUNCH.
    assign timeout_hit = ((state == WAIT_ACTIVE) || (state == WAIT_DONE)) &&
                         (cnt == CNT_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == LAUNCH)
                cnt <= '0;
            else if ((state == WAIT_ACTIVE) || (state == WAIT_DONE))
                cnt <= cnt + CNT_W'(1);
            timed_out <= timeout_hit;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            ptr              <= '0;
            winner           <= '0;
            uart_data        <= '0;
            uart_parity_type <= '0;
            uart_baud_rate   <= '0;
            tx_done_q        <= 1'b0;
            done_pend        <= 1'b0;
        end else begin
            state     <= state_next;
            tx_done_q <= uart_tx_done;
            if ((state == IDLE) && found) begin
                winner           <= pick;
                uart_data        <= sel_data;
                uart_parity_type <= sel_parity;
                uart_baud_rate   <= sel_baud;
            end
            // A done edge arriving with active would be lost to tx_done_q in WAIT_DONE; hold it.
            if (state == LAUNCH)
                done_pend <= 1'b0;
            else if ((state == WAIT_ACTIVE) && uart_tx_active && done_rise)
                done_pend <= 1'b1;
            if (state == RELEASE)
                ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        gnt         = '0;
        done        = '0;
        busy        = (state != IDLE);
        uart_send   = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (found)
                    state_next = LAUNCH;
            end
            LAUNCH: begin
                gnt[winner] = 1'b1;
                uart_send   = 1'b1;
                state_next  = WAIT_ACTIVE;
            end
            WAIT_ACTIVE: begin
                uart_send = 1'b1;
                if (uart_tx_active)
                    state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise || done_pend)
                    state_next = RELEASE;
            end
            RELEASE: begin
                done[winner] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                timeout_err  = timed_out;
`endif
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        if (timeout_hit)
            state_next = RELEASE;
`endif
    end

endmodule
